// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the single-port SRAM arbiter.
// Owner encoding tags the in-flight transaction so its response reaches the right port.
package sram_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STREAK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant decision for the shared SRAM: data wins unless fetch has already waited
// through STREAK_MAX consecutive data grants.
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt_inst,
  output logic gnt_data
);

  localparam int            SW         = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  logic [SW-1:0] streak;

  // Nothing is granted while reset is held, so the result is one-hot or zero.
  always_comb begin
    gnt_data = !rst && data_req && ((streak < STREAK_LIM) || !inst_req);
    gnt_inst = !rst && inst_req && !gnt_data;
  end

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!inst_req || gnt_inst) begin
      streak <= '0;
    end else if (gnt_data && (streak != STREAK_LIM)) begin
      streak <= streak + STREAK_ONE;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency) between instruction fetch
// and data ports; one acceptance per cycle, response exactly one cycle later.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_req,
  input  logic [DATA_W/8-1:0] inst_wen,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic   gnt_inst;
  logic   gnt_data;
  owner_e owner_p1;

  sram_arb_grant #(
    .STREAK_MAX (STREAK_MAX)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .inst_req (inst_req),
    .data_req (data_req),
    .gnt_inst (gnt_inst),
    .gnt_data (gnt_data)
  );

  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;

  // Stage p0: drive the SRAM from whichever port was granted this cycle.
  always_comb begin
    mem_en    = gnt_inst || gnt_data;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_data) begin
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (gnt_inst) begin
      mem_wen   = inst_wen;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_p1 <= OWN_NONE;
    end else if (gnt_data) begin
      owner_p1 <= OWN_DATA;
    end else if (gnt_inst) begin
      owner_p1 <= OWN_INST;
    end else begin
      owner_p1 <= OWN_NONE;
    end
  end

  // Stage p1: SRAM read data is back; a reset in this cycle drops the response.
  assign inst_data_ok = !rst && (owner_p1 == OWN_INST);
  assign data_data_ok = !rst && (owner_p1 == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table plus hand sequences
// for starvation, back-to-back traffic, reset mid-flight and idle.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, data_req;
  logic [3:0]  inst_wen, data_wen;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests;
  int failed;

  sram_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STREAK_MAX (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wen     (inst_wen),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, word-indexed by byte address bits [11:2].
  logic [31:0] sram [1024];

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
    sram[64] <= 32'hDEADBEEF;
    sram[65] <= 32'h01234567;
    mem_rdata <= 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) sram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr[11:2]];
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [3:0]  iwen;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic        dreq;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_iok;
    logic        e_dok;
    logic        e_men;
    logic [3:0]  e_mwen;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_idok;
    logic        e_ddok;
    logic        rd_chk;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[10];

  bit   [0:9]  pat;
  logic [31:0] b_addr [6];
  logic [31:0] b_exp  [6];

  initial begin
    tests = 0;
    failed = 0;

    //        ireq  iwen   iaddr         iwdata         dreq  dwen   daddr         dwdata         iok   dok   men   mwen   maddr         mwdata         idok  ddok  rdchk rd
    vt[0] = '{1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 4'h0, 32'h100,      32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b1, 4'h0, 32'h100,      32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[3] = '{1'b1, 4'h0, 32'h104,      32'h0,         1'b1, 4'hF, 32'h200,      32'h12345678,  1'b0, 1'b1, 1'b1, 4'hF, 32'h200,      32'h12345678,  1'b0, 1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b1, 4'h0, 32'h104,      32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b1, 4'h0, 32'h104,      32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
    vt[5] = '{1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 4'h0, 32'h200,      32'h0,         1'b0, 1'b1, 1'b1, 4'h0, 32'h200,      32'h0,         1'b1, 1'b0, 1'b1, 32'h01234567};
    vt[6] = '{1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b1, 1'b1, 32'h12345678};
    vt[7] = '{1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 4'h3, 32'h300,      32'hAAAA5555,  1'b0, 1'b1, 1'b1, 4'h3, 32'h300,      32'hAAAA5555,  1'b0, 1'b0, 1'b0, 32'h0};
    vt[8] = '{1'b1, 4'hC, 32'h304,      32'hCAFEF00D,  1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b1, 4'hC, 32'h304,      32'hCAFEF00D,  1'b0, 1'b1, 1'b0, 32'h0};
    vt[9] = '{1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 32'h0};

    pat = 10'b1111011110;
    b_addr = '{32'h300, 32'h304, 32'h200, 32'h100, 32'h104, 32'h300};
    b_exp  = '{32'h00005555, 32'hCAFE0000, 32'h12345678, 32'hDEADBEEF, 32'h01234567, 32'h00005555};

    rst = 1'b1;
    inst_req = 1'b0; inst_wen = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_iok",  0, inst_addr_ok, 1'b0);
    chk("rst_dok",  0, data_addr_ok, 1'b0);
    chk("rst_idok", 0, inst_data_ok, 1'b0);
    chk("rst_ddok", 0, data_data_ok, 1'b0);
    chk("rst_men",  0, mem_en, 1'b0);
    chk("rst_mwen", 0, mem_wen, 4'h0);
    rst = 1'b0;

    // Vector table: one entry per cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst_req = vt[i].ireq; inst_wen = vt[i].iwen; inst_addr = vt[i].iaddr; inst_wdata = vt[i].iwdata;
      data_req = vt[i].dreq; data_wen = vt[i].dwen; data_addr = vt[i].daddr; data_wdata = vt[i].dwdata;
      #2;
      chk("v_iok",    i, inst_addr_ok, vt[i].e_iok);
      chk("v_dok",    i, data_addr_ok, vt[i].e_dok);
      chk("v_men",    i, mem_en,       vt[i].e_men);
      chk("v_mwen",   i, mem_wen,      vt[i].e_mwen);
      chk("v_maddr",  i, mem_addr,     vt[i].e_maddr);
      chk("v_mwdata", i, mem_wdata,    vt[i].e_mwdata);
      chk("v_idok",   i, inst_data_ok, vt[i].e_idok);
      chk("v_ddok",   i, data_data_ok, vt[i].e_ddok);
      if (vt[i].rd_chk)
        chk("v_rdata", i, vt[i].e_idok ? inst_rdata : data_rdata, vt[i].e_rd);
    end

    // Starvation: both ports hold reads; expect D,D,D,D,I,D,D,D,D,I
    @(negedge clk);
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    inst_req = 1'b1; inst_wen = 4'h0; inst_addr = 32'h100; inst_wdata = 32'h0;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h200; data_wdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      chk("stv_dok", k, data_addr_ok, pat[k]);
      chk("stv_iok", k, inst_addr_ok, !pat[k]);
      if (k > 0) chk("stv_ddok", k, data_data_ok, pat[k-1]);
    end

    // Back-to-back alternating single requests: data, inst, data, ...
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      data_req = (k < 6) && (k % 2 == 0);
      inst_req = (k < 6) && (k % 2 == 1);
      data_addr = (k < 6) ? b_addr[k] : 32'h0;
      inst_addr = (k < 6) ? b_addr[k] : 32'h0;
      #2;
      if (k < 6) begin
        chk("b2b_men", k, mem_en, 1'b1);
        chk("b2b_maddr", k, mem_addr, b_addr[k]);
        chk("b2b_aok", k, (k % 2 == 0) ? data_addr_ok : inst_addr_ok, 1'b1);
      end
      if (k > 0) begin
        chk("b2b_idok", k, inst_data_ok, ((k - 1) % 2) == 1);
        chk("b2b_ddok", k, data_data_ok, ((k - 1) % 2) == 0);
        chk("b2b_rdata", k, ((k - 1) % 2 == 0) ? data_rdata : inst_rdata, b_exp[k-1]);
      end
    end

    // Reset mid-flight: data read accepted, reset the next cycle
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h200; data_wdata = 32'h0;
    #2;
    chk("rmf_accept", 0, data_addr_ok, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    data_req = 1'b0;
    #2;
    chk("rmf_ddok", 0, data_data_ok, 1'b0);
    chk("rmf_idok", 0, inst_data_ok, 1'b0);
    chk("rmf_men",  0, mem_en, 1'b0);
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h104;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h300; data_wdata = 32'h55AA55AA;
    #2;
    chk("rmf_iok_rst",  0, inst_addr_ok, 1'b0);
    chk("rmf_dok_rst",  0, data_addr_ok, 1'b0);
    chk("rmf_men_rst",  0, mem_en, 1'b0);
    chk("rmf_mwen_rst", 0, mem_wen, 4'h0);
    chk("rmf_maddr_rst", 0, mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    inst_req = 1'b0; data_req = 1'b0;
    #2;
    chk("rmf_ddok_after", 0, data_data_ok, 1'b0);
    chk("rmf_idok_after", 0, inst_data_ok, 1'b0);
    chk("rmf_mwdata_idle", 0, mem_wdata, 32'h0);
    // Streak restarts at 0: four data grants before fetch gets in
    data_wen = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      inst_req = 1'b1; data_req = 1'b1;
      #2;
      chk("rmf_streak_dok", k, data_addr_ok, k < 4);
      chk("rmf_streak_iok", k, inst_addr_ok, k == 4);
    end

    // Idle: one drain cycle, then five quiet cycles
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("idle_men",  k, mem_en, 1'b0);
      chk("idle_iok",  k, inst_addr_ok, 1'b0);
      chk("idle_dok",  k, data_addr_ok, 1'b0);
      chk("idle_idok", k, inst_data_ok, 1'b0);
      chk("idle_ddok", k, data_data_ok, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM (1-cycle read latency) between the core's instruction-fetch port and its data port. Sits between `mycpu_core` (after address translation) and the unified memory. Accepts at most one request per cycle, gives data priority with an anti-starvation streak limit for fetch, and returns each response exactly one cycle after acceptance.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width (byte enables = `DATA_W/8`).
- `STREAK_MAX`, default 4: maximum consecutive data grants while fetch is waiting; legal range 1..15.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  fetch request.
- `inst_wen`  in  DATA_W/8  byte write enables (0 = read).
- `inst_addr`  in  ADDR_W  physical address.
- `inst_wdata`  in  DATA_W  write data.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok`  out  1  response for the accepted fetch.
- `inst_rdata`  out  DATA_W  read data, valid with `inst_data_ok`.
- `data_req`, `data_wen`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same as the `inst_*` ports, for the data port.
- `mem_en`  out  1  SRAM enable.
- `mem_wen`  out  DATA_W/8  SRAM byte write enables.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `mem_rdata`  in  DATA_W  SRAM read data, one cycle after `mem_en`.

## Operation
**Handshake**
- A requester holds `req`, `wen`, `addr` and `wdata` stable until it sees `addr_ok` high.
- Acceptance is the cycle where `req && addr_ok`.
- `addr_ok` is combinational from the current requests and the streak count.

**Grant rule**, evaluated each cycle:
- Grant data if `data_req && (streak < STREAK_MAX || !inst_req)`.
- Otherwise grant inst if `inst_req`.
- Otherwise grant nothing.

**SRAM drive**
- `mem_en` is high when either port is granted.
- `mem_wen`, `mem_addr` and `mem_wdata` are muxed from the granted port.
- With no grant, `mem_en` and `mem_wen` are 0 and `mem_addr`/`mem_wdata` are 0.

**Streak counter**, width `$clog2(STREAK_MAX+1)`:
- Increments, saturating at `STREAK_MAX`, on a data grant while `inst_req` is high.
- Clears to 0 on an inst grant, or in any cycle where `inst_req` is low.

**Owner register**
- States: NONE, INST, DATA.
- Next state is the grant made this cycle (NONE if no grant).
- Transitions between any states are allowed every cycle.

**Responses**
- `inst_data_ok = (owner == INST)`; `data_data_ok = (owner == DATA)`.
- `inst_rdata` and `data_rdata` are both wired directly to `mem_rdata`; each is valid only with its own `data_ok`.
- Writes also produce `data_ok` one cycle after acceptance; their rdata is don't-care.

**No buffering**
- Requesters must accept a response in the cycle it is presented.
- There is no back-pressure on responses.

## Timing
- Acceptance in cycle N means `mem_en` is high in N, and `*_data_ok` with rdata appears in N+1.
- Throughput is one transaction per cycle. Back-to-back grants alternate owner without bubbles.
- Both ports requesting in the same cycle: exactly one `addr_ok` is high. The loser retries with held signals.
- Reset values:
  - All `*_addr_ok` and `*_data_ok` outputs are 0.
  - `mem_en` and `mem_wen` are 0.
  - owner = NONE, streak = 0.
- Reset asserted the cycle after an acceptance: that response is dropped and no `data_ok` is produced.
- Requests during reset are not accepted: `addr_ok` is forced to 0 while `rst` is high.

## Structure
- Package `sram_arb_pkg` holds:
  - the 2-bit owner encoding constants `OWN_NONE = 0`, `OWN_INST = 1`, `OWN_DATA = 2`;
  - the default widths.
- Sub-module `sram_arb_grant` contains the grant rule plus the streak counter. It outputs `gnt_inst` and `gnt_data`, which are one-hot or zero.
- The top level holds the owner register, the SRAM mux and the response routing.

## Test plan
- **Single read:** `inst_req = 1`, `inst_addr = 0x100`, wen = 0, memory[0x100] = 0xDEADBEEF.
  - Cycle N: `inst_addr_ok = 1`, `mem_en = 1`, `mem_addr = 0x100`.
  - Cycle N+1: `inst_data_ok = 1`, `inst_rdata = 0xDEADBEEF`.
- **Contention:** both ports request in the same cycle, `data_wen = 4'hF`, `data_addr = 0x200`, `data_wdata = 0x12345678`.
  - Data is accepted first; inst is accepted in the next cycle.
  - A subsequent read of 0x200 returns 0x12345678.
- **Starvation:** `data_req` held high continuously, `inst_req` high, `STREAK_MAX = 4`.
  - Grant sequence is D, D, D, D, I, D, D, D, D, I.
- **Back-to-back:** alternating single-cycle requests for 6 cycles.
  - `mem_en` stays high for all 6 cycles.
  - Each `data_ok` is routed to the correct port one cycle after its acceptance.
- **Reset mid-flight:** data read accepted in cycle N, `rst = 1` in cycle N+1.
  - No `data_data_ok` is produced.
  - After reset, all outputs are 0 and the streak is 0.
- **Idle:** no requests for 5 cycles.
  - `mem_en = 0`, both `addr_ok` signals are 0, and no `data_ok` appears.
